// File: rtl/timer_cmd_scheduler.sv
// Purpose: round-robin arbiter that turns requester commands into one-cycle timer control pulses
//          and holds "update at end of period" requests until the addressed timer's end event.
// Ports  : clk_i/rst_i (sync, active-high); req_valid_i/req_ready_o/req_timer_i/req_cmd_i per requester;
//          cnt_end_i per timer; timer_{start,stop,rst,update,arm}_o pulses; active_o, pending_o, err_o.
module timer_cmd_scheduler #(
   parameter  int N_REQ    = 2,
   parameter  int N_TIMERS = 4,
   localparam int TW       = (N_TIMERS > 1) ? $clog2(N_TIMERS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_REQ-1:0]      req_valid_i,
   output logic [N_REQ-1:0]      req_ready_o,
   input  logic [N_REQ*TW-1:0]   req_timer_i,
   input  logic [N_REQ*3-1:0]    req_cmd_i,
   input  logic [N_TIMERS-1:0]   cnt_end_i,
   output logic [N_TIMERS-1:0]   timer_start_o,
   output logic [N_TIMERS-1:0]   timer_stop_o,
   output logic [N_TIMERS-1:0]   timer_rst_o,
   output logic [N_TIMERS-1:0]   timer_update_o,
   output logic [N_TIMERS-1:0]   timer_arm_o,
   output logic [N_TIMERS-1:0]   active_o,
   output logic [N_TIMERS-1:0]   pending_o,
   output logic                  err_o
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      CMD_START      = 3'd0,
      CMD_STOP       = 3'd1,
      CMD_RST        = 3'd2,
      CMD_UPDATE     = 3'd3,
      CMD_ARM        = 3'd4,
      CMD_UPD_AT_END = 3'd5
   } cmd_e;

   logic [PW-1:0]       ptr_q, ptr_d;
   logic [N_TIMERS-1:0] start_q, start_d;
   logic [N_TIMERS-1:0] stop_q, stop_d;
   logic [N_TIMERS-1:0] trst_q, trst_d;
   logic [N_TIMERS-1:0] upd_q, upd_d;
   logic [N_TIMERS-1:0] arm_q, arm_d;
   logic [N_TIMERS-1:0] active_q, active_d;
   logic [N_TIMERS-1:0] pending_q, pending_d;
   logic                err_q, err_d;

   logic                gnt_any;
   int                  gnt_idx;
   int                  srch_idx;
   logic [TW-1:0]       sel_timer;
   logic [2:0]          sel_cmd;
   logic                cmd_ok;
   logic                tidx_ok;
   logic [N_TIMERS-1:0] tmask;
   logic [N_TIMERS-1:0] fire;

   // Round-robin search starting at the pointer; no grant is possible during reset.
   always_comb begin
      gnt_any     = 1'b0;
      gnt_idx     = 0;
      srch_idx    = 0;
      req_ready_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         srch_idx = int'(ptr_q) + i;
         if (srch_idx >= N_REQ) srch_idx = srch_idx - N_REQ;
         if (!gnt_any && req_valid_i[srch_idx] && !rst_i) begin
            gnt_any = 1'b1;
            gnt_idx = srch_idx;
         end
      end
      if (gnt_any) req_ready_o[gnt_idx] = 1'b1;
   end

   assign sel_timer = req_timer_i[gnt_idx*TW +: TW];
   assign sel_cmd   = req_cmd_i[gnt_idx*3 +: 3];
   assign cmd_ok    = (sel_cmd <= 3'd5);
   assign tidx_ok   = (int'(sel_timer) < N_TIMERS);
   assign tmask     = N_TIMERS'(1) << sel_timer;
   assign fire      = pending_q & cnt_end_i;

   always_comb begin
      ptr_d     = ptr_q;
      start_d   = '0;
      stop_d    = '0;
      trst_d    = '0;
      // Deferred updates fire first; a same-cycle command on that timer can only add to this.
      upd_d     = fire;
      arm_d     = '0;
      active_d  = active_q;
      pending_d = pending_q & ~fire;
      err_d     = 1'b0;

      if (gnt_any) begin
         ptr_d = (gnt_idx + 1 >= N_REQ) ? '0 : PW'(gnt_idx + 1);
         if (cmd_ok && tidx_ok) begin
            case (cmd_e'(sel_cmd))
               CMD_START: begin
                  start_d  = tmask;
                  active_d = active_q | tmask;
               end
               CMD_STOP: begin
                  stop_d    = tmask;
                  active_d  = active_q & ~tmask;
                  pending_d = pending_d & ~tmask;
               end
               CMD_RST: begin
                  trst_d    = tmask;
                  pending_d = pending_d & ~tmask;
               end
               CMD_UPDATE: begin
                  upd_d     = upd_d | tmask;
                  pending_d = pending_d & ~tmask;
               end
               CMD_ARM:        arm_d     = tmask;
               // Set after the fire clear so an end event in the same cycle does not consume it.
               CMD_UPD_AT_END: pending_d = pending_d | tmask;
               default: ;
            endcase
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q     <= '0;
         start_q   <= '0;
         stop_q    <= '0;
         trst_q    <= '0;
         upd_q     <= '0;
         arm_q     <= '0;
         active_q  <= '0;
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         trst_q    <= trst_d;
         upd_q     <= upd_d;
         arm_q     <= arm_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   assign timer_start_o  = start_q;
   assign timer_stop_o   = stop_q;
   assign timer_rst_o    = trst_q;
   assign timer_update_o = upd_q;
   assign timer_arm_o    = arm_q;
   assign active_o       = active_q;
   assign pending_o      = pending_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_timer_cmd_scheduler.sv
module tb_timer_cmd_scheduler;

   localparam logic [2:0] C_START = 3'd0;
   localparam logic [2:0] C_STOP  = 3'd1;
   localparam logic [2:0] C_UPD   = 3'd3;
   localparam logic [2:0] C_ARM   = 3'd4;
   localparam logic [2:0] C_UAE   = 3'd5;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] valid, valid3;
   logic [1:0] ready, ready3;
   logic [3:0] req_timer;
   logic [5:0] req_cmd;
   logic [3:0] cnt_end;
   logic [3:0] start, stop, trst, upd, arm, active, pending;
   logic       err;
   logic [2:0] start3, stop3, trst3, upd3, arm3, active3, pending3;
   logic       err3;
   logic [28:0] all_out;

   int checks = 0;
   int errors = 0;

   assign all_out = {start, stop, trst, upd, arm, active, pending, err};

   always #5 clk = ~clk;

   timer_cmd_scheduler #(.N_REQ(2), .N_TIMERS(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(valid), .req_ready_o(ready),
      .req_timer_i(req_timer), .req_cmd_i(req_cmd),
      .cnt_end_i(cnt_end),
      .timer_start_o(start), .timer_stop_o(stop), .timer_rst_o(trst),
      .timer_update_o(upd), .timer_arm_o(arm),
      .active_o(active), .pending_o(pending), .err_o(err)
   );

   timer_cmd_scheduler #(.N_REQ(2), .N_TIMERS(3)) dut3 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(valid3), .req_ready_o(ready3),
      .req_timer_i(req_timer), .req_cmd_i(req_cmd),
      .cnt_end_i(cnt_end[2:0]),
      .timer_start_o(start3), .timer_stop_o(stop3), .timer_rst_o(trst3),
      .timer_update_o(upd3), .timer_arm_o(arm3),
      .active_o(active3), .pending_o(pending3), .err_o(err3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requester 0 issues one command to the 4-timer instance; checks its combinational grant.
   task automatic issue(input logic [2:0] c, input logic [1:0] t);
      valid        = 2'b01;
      req_cmd[2:0] = c;
      req_timer[1:0] = t;
      #1;
      chk("issue_rdy", ready, 2'b01);
      tick();
      valid = 2'b00;
   endtask

   task automatic issue3(input logic [2:0] c, input logic [1:0] t);
      valid3       = 2'b01;
      req_cmd[2:0] = c;
      req_timer[1:0] = t;
      #1;
      chk("issue3_rdy", ready3, 2'b01);
      tick();
      valid3 = 2'b00;
   endtask

   initial begin
      rst = 1'b1; valid = 2'b11; valid3 = 2'b11;
      req_cmd = '0; req_timer = '0; cnt_end = '0;

      // Reset: no grants while reset is held
      repeat (3) begin
         @(negedge clk);
         chk("rst_rdy", ready, 2'b00);
         chk("rst_rdy3", ready3, 2'b00);
      end
      tick();
      rst = 1'b0; valid = 2'b00; valid3 = 2'b00;
      chk("rst_out", all_out, 29'd0);
      tick();
      chk("rst_out2", all_out, 29'd0);

      // Round-robin: r0 START t0, r1 ARM t1, both always valid
      valid = 2'b11;
      req_cmd = {C_ARM, C_START};
      req_timer = {2'd1, 2'd0};
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_rdy", ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         chk("rr_start", start, (k % 2 == 0) ? 4'b0001 : 4'b0000);
         chk("rr_arm", arm, (k % 2 == 0) ? 4'b0000 : 4'b0010);
      end
      valid = 2'b00;
      chk("rr_active", active, 4'b0001);

      // Deferred update on t2
      issue(C_UAE, 2'd2);
      chk("def_pend0", pending, 4'b0100);
      chk("def_upd0", upd, 4'b0000);
      repeat (4) begin
         tick();
         chk("def_wait", {upd, pending}, 8'h04);
      end
      cnt_end = 4'b0100;
      tick();
      cnt_end = 4'b0000;
      chk("def_fire_upd", upd, 4'b0100);
      chk("def_fire_pend", pending, 4'b0000);
      tick();
      chk("def_after", upd, 4'b0000);

      // Collision: deferred fire with UPDATE on the same timer -> one pulse
      issue(C_START, 2'd1);
      chk("col_start", start, 4'b0010);
      chk("col_active", active, 4'b0011);
      issue(C_UAE, 2'd1);
      chk("col_pend", pending, 4'b0010);
      cnt_end = 4'b0010;
      issue(C_UPD, 2'd1);
      cnt_end = 4'b0000;
      chk("colu_upd", upd, 4'b0010);
      chk("colu_pend", pending, 4'b0000);
      tick();
      chk("colu_once", upd, 4'b0000);

      // Collision: deferred fire with STOP -> update and stop together
      issue(C_UAE, 2'd1);
      cnt_end = 4'b0010;
      issue(C_STOP, 2'd1);
      cnt_end = 4'b0000;
      chk("cols_upd", upd, 4'b0010);
      chk("cols_stop", stop, 4'b0010);
      chk("cols_active", active, 4'b0001);
      chk("cols_pend", pending, 4'b0000);

      // UPD_AT_END accepted while the end event is already present -> waits for the next one
      cnt_end = 4'b1000;
      issue(C_UAE, 2'd3);
      cnt_end = 4'b0000;
      chk("uae_end_pend", pending, 4'b1000);
      chk("uae_end_upd", upd, 4'b0000);
      cnt_end = 4'b1000;
      tick();
      cnt_end = 4'b0000;
      chk("uae_next_upd", upd, 4'b1000);
      chk("uae_next_pend", pending, 4'b0000);

      // Reserved commands
      issue(3'd6, 2'd0);
      chk("err6", {start, stop, trst, upd, arm, active, pending, err}, {20'h0, 4'b0001, 4'b0000, 1'b1});
      issue(3'd7, 2'd2);
      chk("err7", {start, stop, trst, upd, arm, active, pending, err}, {20'h0, 4'b0001, 4'b0000, 1'b1});
      tick();
      chk("err_clear", err, 1'b0);

      // Three-timer instance: index 3 and reserved cmd are errors, index 2 is legal
      issue3(C_START, 2'd3);
      chk("e3_idx", {start3, stop3, trst3, upd3, arm3, active3, pending3, err3}, {21'h0, 1'b1});
      issue3(3'd6, 2'd0);
      chk("e3_cmd", {start3, stop3, trst3, upd3, arm3, active3, pending3, err3}, {21'h0, 1'b1});
      issue3(C_START, 2'd2);
      chk("e3_ok", {start3, active3, err3}, {3'b100, 3'b100, 1'b0});

      // Reset mid-operation
      for (int t = 0; t < 4; t++) issue(C_UAE, 2'(t));
      chk("mid_pend", pending, 4'b1111);
      issue(C_START, 2'd2);
      chk("mid_start", start, 4'b0100);
      rst = 1'b1; valid = 2'b11; cnt_end = 4'b1111;
      req_cmd = {C_ARM, C_START};
      req_timer = {2'd1, 2'd0};
      #1;
      chk("mid_rdy", ready, 2'b00);
      tick();
      chk("mid_out", all_out, 29'd0);
      rst = 1'b0; valid = 2'b00; cnt_end = 4'b0000;
      tick();
      chk("mid_out2", all_out, 29'd0);

      // Pointer returns to requester 0 after reset
      valid = 2'b11;
      #1;
      chk("ptr_rdy", ready, 2'b01);
      tick();
      valid = 2'b00;
      chk("ptr_start", {start, arm}, {4'b0001, 4'b0000});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
